// File: rtl/seg_7_pkg.sv
// Shared segment-pattern constants, code values and decode result type for the scan decoder.
package seg_7_pkg;

    // Segment order a..g, MSB = a, 1 = lit
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1110011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef struct packed {
        logic [3:0] code;
        logic       valid;
        logic       err;
    } seg_res_t;

endpackage

// File: rtl/seg_7_pattern_decode.sv
// Purpose: map one 7-segment pattern to {code, valid, err}.
// Latency: combinational.
// Backpressure: none.
module seg_7_pattern_decode
    import seg_7_pkg::*;
(
    input  logic [6:0] seg,
    output seg_res_t   res
);

    always_comb begin
        res = '{code: CODE_ERR, valid: 1'b0, err: 1'b1};
        case (seg)
            SEG_0:     res = '{code: 4'd0, valid: 1'b1, err: 1'b0};
            SEG_1:     res = '{code: 4'd1, valid: 1'b1, err: 1'b0};
            SEG_2:     res = '{code: 4'd2, valid: 1'b1, err: 1'b0};
            SEG_3:     res = '{code: 4'd3, valid: 1'b1, err: 1'b0};
            SEG_4:     res = '{code: 4'd4, valid: 1'b1, err: 1'b0};
            SEG_5:     res = '{code: 4'd5, valid: 1'b1, err: 1'b0};
            SEG_6:     res = '{code: 4'd6, valid: 1'b1, err: 1'b0};
            SEG_7:     res = '{code: 4'd7, valid: 1'b1, err: 1'b0};
            SEG_8:     res = '{code: 4'd8, valid: 1'b1, err: 1'b0};
            SEG_9:     res = '{code: 4'd9, valid: 1'b1, err: 1'b0};
            SEG_BLANK: res = '{code: CODE_BLANK, valid: 1'b0, err: 1'b0};
            default:   res = '{code: CODE_ERR, valid: 1'b0, err: 1'b1};
        endcase
    end

endmodule

// File: rtl/seg_7_scan_decoder.sv
// Purpose: glitch-filter a scanned 7-segment bus, keep per-digit codes, emit change events.
// Latency: STABLE_CNT+1 edges from first sample of a new pattern to register file/event update.
// Backpressure: 1-deep event register; events arriving while it is held are dropped and ovf sticks.
module seg_7_scan_decoder
    import seg_7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [2:0]            upd_digit,
    output logic [3:0]            upd_code,
    output logic                  ovf
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int SW = DIGITS + 7;

    logic [SW-1:0] sample;
    logic [SW-1:0] prev_sample;
    logic [CW-1:0] cnt;
    logic          one_hot;
    logic          match;
    logic          commit;
    logic          changed;
    logic          new_evt;
    logic          accept;
    logic [2:0]    sel_idx;
    logic [3:0]    cur_code;
    logic          cur_err;
    seg_res_t      res;

    seg_7_pattern_decode u_decode (
        .seg (seg_in),
        .res (res)
    );

    assign sample  = {dig_sel, seg_in};
    assign one_hot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
    assign match   = one_hot && (sample == prev_sample);
    // Commit fires only on the single edge the run counter reaches its limit
    assign commit  = match && (cnt == CW'(STABLE_CNT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= '0;
            cnt         <= '0;
        end else begin
            prev_sample <= sample;
            if (!match)
                cnt <= '0;
            else if (cnt != CW'(STABLE_CNT))
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        sel_idx  = '0;
        cur_code = CODE_BLANK;
        cur_err  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_sel[i]) begin
                sel_idx  = 3'(i);
                cur_code = bcd_out[4*i +: 4];
                cur_err  = digit_err[i];
            end
        end
    end

    assign changed = {res.code, res.err} != {cur_code, cur_err};
    assign new_evt = commit && changed;
    assign accept  = upd_valid && upd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_out     <= {DIGITS{CODE_BLANK}};
            digit_valid <= '0;
            digit_err   <= '0;
        end else if (commit) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (dig_sel[i]) begin
                    bcd_out[4*i +: 4] <= res.code;
                    digit_valid[i]    <= res.valid;
                    digit_err[i]      <= res.err;
                end
            end
        end
    end

    // A slot is free if empty or being drained this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid <= 1'b0;
            upd_digit <= '0;
            upd_code  <= '0;
            ovf       <= 1'b0;
        end else if (new_evt) begin
            if (!upd_valid || upd_ready) begin
                upd_valid <= 1'b1;
                upd_digit <= sel_idx;
                upd_code  <= res.code;
            end else begin
                ovf <= 1'b1;
            end
        end else if (accept) begin
            upd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_7_scan_decoder.sv
// Directed bench: expected change events queued by stimulus, popped by an independent monitor.
module tb_seg_7_scan_decoder;

    localparam int DIGITS     = 4;
    localparam int STABLE_CNT = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [6:0]           seg_in = '0;
    logic [DIGITS-1:0]    dig_sel = '0;
    logic                 upd_ready = 1'b1;
    logic [4*DIGITS-1:0]  bcd_out;
    logic [DIGITS-1:0]    digit_valid;
    logic [DIGITS-1:0]    digit_err;
    logic                 upd_valid;
    logic [2:0]           upd_digit;
    logic [3:0]           upd_code;
    logic                 ovf;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] exp_q[$];
    logic [6:0] pats[4];

    seg_7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(STABLE_CNT)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_digit   (upd_digit),
        .upd_code    (upd_code),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bcd"},   32'(bcd_out),     32'hFFFF);
        chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
        chk({tag, "_err"},   32'(digit_err),   32'h0);
        chk({tag, "_updv"},  32'(upd_valid),   32'h0);
        chk({tag, "_updd"},  32'(upd_digit),   32'h0);
        chk({tag, "_updc"},  32'(upd_code),    32'h0);
        chk({tag, "_ovf"},   32'(ovf),         32'h0);
    endtask

    // Monitor: every handshake seen here completes on the following rising edge
    logic [6:0] mon_exp;
    always @(negedge clk) begin
        if (!rst && upd_valid && upd_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL evt_unexpected: got digit %0d code %0h expected no event", upd_digit, upd_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({upd_digit, upd_code} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL evt: got digit %0d code %0h expected digit %0d code %0h",
                             upd_digit, upd_code, mon_exp[6:4], mon_exp[3:0]);
                end
            end
        end
    end

    initial begin
        pats[0] = 7'b0110000;
        pats[1] = 7'b1101101;
        pats[2] = 7'b1111001;
        pats[3] = 7'b0110011;

        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst0");
        rst = 1'b0;

        // Run aborted one edge short of commit
        hold(4'b0001, 7'b1111001, 3);
        chk("short_bcd",  32'(bcd_out),   32'hFFFF);
        chk("short_updv", 32'(upd_valid), 32'h0);
        hold(4'b0000, 7'b0000000, 1);
        chk("short_bcd2", 32'(bcd_out),     32'hFFFF);
        chk("short_dv",   32'(digit_valid), 32'h0);

        // Full run: digit 0 becomes 3
        exp_q.push_back({3'd0, 4'd3});
        hold(4'b0001, 7'b1111001, 4);
        chk("d0_bcd",  32'(bcd_out[3:0]), 32'h3);
        chk("d0_dv",   32'(digit_valid),  32'h1);
        chk("d0_updv", 32'(upd_valid),    32'h1);
        hold(4'b0000, 7'b0000000, 2);

        // Scan 1,2,3,4 twice; the second pass must be silent
        exp_q.push_back({3'd0, 4'd1});
        exp_q.push_back({3'd1, 4'd2});
        exp_q.push_back({3'd2, 4'd3});
        exp_q.push_back({3'd3, 4'd4});
        for (int p = 0; p < 2; p++)
            for (int d = 0; d < 4; d++)
                hold(4'(1 << d), pats[d], 6);
        hold(4'b0000, 7'b0000000, 2);
        chk("scan_bcd",  32'(bcd_out),     32'h4321);
        chk("scan_dv",   32'(digit_valid), 32'hF);
        chk("scan_ovf",  32'(ovf),         32'h0);
        chk("scan_qlen", 32'(exp_q.size()), 32'h0);

        // Illegal pattern on digit 1
        exp_q.push_back({3'd1, 4'hE});
        hold(4'b0010, 7'b1000001, 4);
        chk("ill_bcd", 32'(bcd_out),     32'h43E1);
        chk("ill_err", 32'(digit_err),   32'h2);
        chk("ill_dv",  32'(digit_valid), 32'hD);
        hold(4'b0000, 7'b0000000, 2);

        // Backpressure: second event dropped, register file still updated
        upd_ready = 1'b0;
        exp_q.push_back({3'd2, 4'd5});
        hold(4'b0100, 7'b1011011, 4);
        hold(4'b0000, 7'b0000000, 1);
        hold(4'b1000, 7'b1110000, 4);
        chk("bp_ovf",  32'(ovf),         32'h1);
        chk("bp_updv", 32'(upd_valid),   32'h1);
        chk("bp_updd", 32'(upd_digit),   32'h2);
        chk("bp_updc", 32'(upd_code),    32'h5);
        chk("bp_bcd",  32'(bcd_out),     32'h75E1);
        chk("bp_dv",   32'(digit_valid), 32'hD);
        upd_ready = 1'b1;
        hold(4'b0000, 7'b0000000, 2);
        chk("bp_drain", 32'(upd_valid), 32'h0);

        // Non-one-hot select never commits
        hold(4'b0011, 7'b1111110, 6);
        chk("mh_bcd",  32'(bcd_out),   32'h75E1);
        chk("mh_updv", 32'(upd_valid), 32'h0);

        // Reset mid-run, then the held pattern restarts counting from zero
        hold(4'b0001, 7'b1111110, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("rst1");
        rst = 1'b0;
        hold(4'b0001, 7'b1111110, 3);
        chk("post_rst_bcd", 32'(bcd_out), 32'hFFFF);
        exp_q.push_back({3'd0, 4'd0});
        hold(4'b0001, 7'b1111110, 1);
        chk("post_rst_bcd2", 32'(bcd_out),     32'hFFF0);
        chk("post_rst_dv",   32'(digit_valid), 32'h1);
        hold(4'b0000, 7'b0000000, 3);
        chk("final_qlen", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
